// File: rtl/uart_rx.sv
// uart_rx - 8N1 serial receiver (LSB first, idle-high line), self-timed from clk.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-low reset (0 = reset)
//   en          in   1  receiver enable; 0 aborts the frame and holds IDLE
//   rx          in   1  asynchronous serial input, idles at 1
//   data_out    out  8  last correctly framed byte, held until the next good byte
//   data_valid  out  1  one-cycle pulse when data_out has just been updated
//   frame_err   out  1  one-cycle pulse when the stop bit is sampled as 0
//   busy        out  1  high in every state except IDLE
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 130
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    sync1_d   = rx;
    sync2_d   = sync1_q;

    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) state_d = START;
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            if (!rx_s) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Counter restarts on any state change and at the end of each bit period
    // so DATA can sample eight consecutive bits without leaving the state.
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_IDLE ||
        cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx (CLKS_PER_BIT = 130).
// Good frames push their byte to a queue; a monitor pops and compares on
// every data_valid pulse. Scenario tasks check pulse counts and levels.
module tb_uart_rx;

  localparam int unsigned CPB  = 130;
  localparam int unsigned HALF = CPB / 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  int ferr_cnt     = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid data_out=%h expected no pulse", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          tests_failed++;
          $display("FAIL sb_data got %h expected %h", data_out, e);
        end
      end
    end
    if (frame_err) ferr_cnt++;
    if (data_valid || frame_err) begin
      tests_run++;
      if ((data_valid && frame_err) || !rst) begin
        tests_failed++;
        $display("FAIL pulse_excl valid=%b ferr=%b rst=%b expected single pulse outside reset",
                 data_valid, frame_err, rst);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic good);
    if (good) exp_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; rx = 1'b1;
    tick(3);
    tests_run++;
    if ({data_out, data_valid, frame_err, busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_vals got %h/%b/%b/%b expected 00/0/0/0",
               data_out, data_valid, frame_err, busy);
    end
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(10);
    tests_run++;
    if (valid_cnt - v0 != 1 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL single_pulses got valid=%0d ferr=%0d expected 1/0", valid_cnt - v0, ferr_cnt - f0);
    end
    tests_run++;
    if (data_out !== 8'hA5 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_out got %h busy=%b expected a5 busy=0", data_out, busy);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'hB4, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    tick(10);
    tests_run++;
    if (valid_cnt - v0 != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_count got %0d pending=%0d expected 2/0", valid_cnt - v0, exp_q.size());
    end
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL b2b_last got %h expected 00", data_out);
    end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    tick(20);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_busy got %b expected 1", busy);
    end
    rx = 1'b1;
    tick(HALF + 3);
    tests_run++;
    if (busy !== 1'b0 || valid_cnt != v0 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL glitch_idle got busy=%b valid=%0d ferr=%0d expected 0/0/0",
               busy, valid_cnt - v0, ferr_cnt - f0);
    end
    tick(CPB);
  endtask

  task automatic test_frame_err;
    int v0, f0;
    send_frame(8'h77, 1'b1, 1'b1);
    tick(5);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(4 * CPB);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ferr_busy got %b expected 1", busy);
    end
    tests_run++;
    if (ferr_cnt - f0 != 1 || valid_cnt != v0) begin
      tests_failed++;
      $display("FAIL ferr_pulses got ferr=%0d valid=%0d expected 1/0", ferr_cnt - f0, valid_cnt - v0);
    end
    tests_run++;
    if (data_out !== 8'h77) begin
      tests_failed++;
      $display("FAIL ferr_hold got %h expected 77", data_out);
    end
    rx = 1'b1;
    tick(5);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_release got busy=%b expected 0", busy);
    end
    tick(CPB);
  endtask

  task automatic test_enable_abort;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    en = 1'b0;
    tick(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy got %b expected 0", busy);
    end
    tick(5 * CPB);
    tests_run++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL abort_pulses got valid=%0d ferr=%0d expected 0/0", valid_cnt - v0, ferr_cnt - f0);
    end
    en = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, 1'b1);
    tick(10);
    tests_run++;
    if (data_out !== 8'h81 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_next got %h pending=%0d expected 81/0", data_out, exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    tick(2);
    tests_run++;
    if ({data_out, data_valid, frame_err, busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL midrst_vals got %h/%b/%b/%b expected 00/0/0/0",
               data_out, data_valid, frame_err, busy);
    end
    rst = 1'b1;
    rx  = 1'b1;
    tick(CPB);
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(10);
    tests_run++;
    if (data_out !== 8'h5A || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_next got %h pending=%0d expected 5a/0", data_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_enable_abort();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
